// File: rtl/lvds_align_ctrl.sv
// ============================================================================
// lvds_align_ctrl
//
// Word-alignment controller for the 12-bit LVDS deserializer. It runs on the
// clk_div domain and drives the reset and bitslip inputs of the ISERDESE2
// master/slave pair. After a SERDES reset and a settling delay it compares
// the parallel word against a known training pattern. It issues single-cycle
// bitslip pulses until the pattern is seen MATCH_COUNT times in a row, then
// reports lock. If MAX_SLIPS pulses are used up without lock, it reports an
// alignment error.
//
// Optional feature macro: LVDS_ALIGN_MONITOR_EN
//   When defined, LOCKED watches data_in while i_train_active is high.
//   LOSS_COUNT consecutive mismatches drop lock and restart the checking
//   phase (no SERDES reset is issued). When undefined, i_train_active is
//   ignored.
//
// Ports:
//   clk_div         in   parallel-word clock
//   rst             in   synchronous active-high reset
//   i_start         in   one-cycle pulse, (re)starts alignment from any state
//   i_data_in       in   12-bit registered deserializer word
//   i_train_active  in   transmitter is sending PATTERN (monitor feature)
//   o_serdes_rst    out  reset to both ISERDESE2 instances
//   o_bitslip       out  one-cycle bitslip pulse to the master ISERDESE2
//   o_locked        out  alignment achieved
//   o_align_err     out  alignment failed after MAX_SLIPS slips
//   o_busy          out  high in every state except IDLE, LOCKED and FAIL
//   o_slip_cnt      out  bitslip pulses issued since the last start
// ============================================================================
module lvds_align_ctrl #(
    parameter logic [11:0] PATTERN       = 12'hFC0,
    parameter int          RST_CYCLES    = 4,
    parameter int          SETTLE_CYCLES = 16,
    parameter int          MATCH_COUNT   = 8,
    parameter int          SLIP_WAIT     = 4,
    parameter int          MAX_SLIPS     = 12,
    parameter int          LOSS_COUNT    = 4,
    localparam int         SLIP_W        = $clog2(MAX_SLIPS + 1)
) (
    input  logic              clk_div,
    input  logic              rst,
    input  logic              i_start,
    input  logic [11:0]       i_data_in,
    input  logic              i_train_active,
    output logic              o_serdes_rst,
    output logic              o_bitslip,
    output logic              o_locked,
    output logic              o_align_err,
    output logic              o_busy,
    output logic [SLIP_W-1:0] o_slip_cnt
);

    // One shared delay counter serves SRST, SETTLE and WAIT, so it is sized
    // for the longest of the three.
    localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ?
                             ((RST_CYCLES > SLIP_WAIT) ? RST_CYCLES : SLIP_WAIT) :
                             ((SETTLE_CYCLES > SLIP_WAIT) ? SETTLE_CYCLES : SLIP_WAIT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int MATCH_W = $clog2(MATCH_COUNT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRST,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_WAIT,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [MATCH_W-1:0]  r_match;
    logic                w_match;

    assign w_match = (i_data_in == PATTERN);

`ifdef LVDS_ALIGN_MONITOR_EN
    localparam int LOSS_W = $clog2(LOSS_COUNT + 1);
    logic [LOSS_W-1:0]   r_lossCnt;
`else
    logic                w_unusedTrain;
    assign w_unusedTrain = i_train_active;
`endif

    // Single FSM register block. Outputs are registered together with the
    // next state, so each output changes on the same edge as the state that
    // owns it. start is handled ahead of the case statement so that it
    // restarts the sequence identically from every state; rst outranks it.
    always_ff @(posedge clk_div) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_match      <= '0;
            o_serdes_rst <= 1'b0;
            o_bitslip    <= 1'b0;
            o_locked     <= 1'b0;
            o_align_err  <= 1'b0;
            o_busy       <= 1'b0;
            o_slip_cnt   <= '0;
`ifdef LVDS_ALIGN_MONITOR_EN
            r_lossCnt    <= '0;
`endif
        end else if (i_start) begin
            r_state      <= S_SRST;
            r_cnt        <= '0;
            r_match      <= '0;
            o_serdes_rst <= 1'b1;
            o_bitslip    <= 1'b0;
            o_locked     <= 1'b0;
            o_align_err  <= 1'b0;
            o_busy       <= 1'b1;
            o_slip_cnt   <= '0;
`ifdef LVDS_ALIGN_MONITOR_EN
            r_lossCnt    <= '0;
`endif
        end else begin
            // bitslip is only ever high for the single cycle spent in SLIP
            o_bitslip <= 1'b0;
            case (r_state)
                S_IDLE: begin
                end
                S_SRST: begin
                    if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        r_state      <= S_SETTLE;
                        r_cnt        <= '0;
                        o_serdes_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        r_state <= S_CHECK;
                        r_cnt   <= '0;
                        r_match <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_match) begin
                        if (r_match == MATCH_W'(MATCH_COUNT - 1)) begin
                            r_state  <= S_LOCKED;
                            r_match  <= '0;
                            o_locked <= 1'b1;
                            o_busy   <= 1'b0;
`ifdef LVDS_ALIGN_MONITOR_EN
                            r_lossCnt <= '0;
`endif
                        end else begin
                            r_match <= r_match + MATCH_W'(1);
                        end
                    end else begin
                        r_match <= '0;
                        if (o_slip_cnt < SLIP_W'(MAX_SLIPS)) begin
                            r_state    <= S_SLIP;
                            o_bitslip  <= 1'b1;
                            o_slip_cnt <= o_slip_cnt + SLIP_W'(1);
                        end else begin
                            r_state     <= S_FAIL;
                            o_align_err <= 1'b1;
                            o_busy      <= 1'b0;
                        end
                    end
                end
                S_SLIP: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                // Words still in the ISERDES pipeline were framed before the
                // slip, so they are skipped rather than compared.
                S_WAIT: begin
                    if (r_cnt == CNT_W'(SLIP_WAIT - 1)) begin
                        r_state <= S_CHECK;
                        r_cnt   <= '0;
                        r_match <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_LOCKED: begin
`ifdef LVDS_ALIGN_MONITOR_EN
                    if (i_train_active && !w_match) begin
                        if (r_lossCnt == LOSS_W'(LOSS_COUNT - 1)) begin
                            r_state    <= S_CHECK;
                            r_lossCnt  <= '0;
                            r_match    <= '0;
                            o_locked   <= 1'b0;
                            o_busy     <= 1'b1;
                            o_slip_cnt <= '0;
                        end else begin
                            r_lossCnt <= r_lossCnt + LOSS_W'(1);
                        end
                    end else begin
                        r_lossCnt <= '0;
                    end
`endif
                end
                S_FAIL: begin
                end
                default: begin
                    r_state      <= S_IDLE;
                    o_serdes_rst <= 1'b0;
                    o_locked     <= 1'b0;
                    o_align_err  <= 1'b0;
                    o_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
